floor_request_input: RTL and testbench

Input-side counterpart to the four-digit floor display driver. Samples the four raw floor-call push buttons on the Basys3, synchronises and debounces each one, and latches every press as a pending request. It then hands the pending requests one at a time to the elevator controller as one-hot floor codes (4'b0001 = floor 1 … 4'b1000 = floor 4) over a valid/ack handshake. These are the same codes the display driver consumes on its state/destination inputs.

---
 rtl/floor_request_input.sv | 104 ++++++++++
 tb/tb_floor_request_input.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/floor_request_input.sv
// Floor-call button front end: synchronise, debounce and latch four push buttons,
// then offer pending requests lowest floor first over a valid/ack handshake.

module floor_request_input_lane #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CW        = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q, stable_q;
  logic [CW-1:0] cnt_q;

  // Rising edge only: a release also flips stable but never raises press.
  assign press_o = sync2_q & ~stable_q & (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

module floor_request_input #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] req_floor,
  output logic       req_valid,
  input  logic       req_ack,
  output logic [3:0] pending
);
  localparam int NUM_FLOORS = 4;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                  state_q;
  logic [NUM_FLOORS-1:0]   press, clear, sel;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   req_floor_q;
  logic                    req_valid_q;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_lane
    floor_request_input_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  assign sel       = pending_q & (~pending_q + 1'b1);
  assign clear     = {NUM_FLOORS{req_valid_q & req_ack}} & req_floor_q;
  // Press beats clear so a re-press landing on the ack edge is not lost.
  assign pending_d = press | (pending_q & ~clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: if (pending_q != '0) begin
          req_floor_q <= sel;
          req_valid_q <= 1'b1;
          state_q     <= OFFER;
        end
        OFFER: if (req_ack) begin
          req_floor_q <= '0;
          req_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign pending   = pending_q;
endmodule

// File: tb/tb_floor_request_input.sv
// Bench for floor_request_input: directed vector table plus random stimulus
// checked every cycle against a history-window reference model.

module tb_floor_request_input;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       req_ack = 1'b0;
  logic [3:0] req_floor, pending;
  logic       req_valid;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  floor_request_input #(.DB_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .req_floor(req_floor),
    .req_valid(req_valid),
    .req_ack  (req_ack),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once sync2 has disagreed with the
  // accepted level for DB consecutive cycles; offers are lowest pending bit.
  logic [3:0] m_s1 = 0, m_s2 = 0, m_stable = 0, m_pend = 0;
  bit         m_valid = 0;
  int         m_off = 0;
  logic [3:0] hist[$];

  task automatic model_step();
    logic [3:0] flip, press, clr;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_pend = 0; m_valid = 0; m_off = 0;
      hist.delete();
      return;
    end
    hist.push_back(m_s2);
    if (hist.size() > DB) void'(hist.pop_front());
    for (int i = 0; i < 4; i++) begin
      flip[i] = (hist.size() == DB);
      foreach (hist[j]) if (hist[j][i] == m_stable[i]) flip[i] = 1'b0;
    end
    press    = flip & m_s2;
    m_stable = m_stable ^ flip;
    clr      = (m_valid && req_ack) ? 4'(1 << m_off) : 4'b0;
    if (m_valid) begin
      if (req_ack) m_valid = 0;
    end else if (m_pend != 0) begin
      for (int i = 3; i >= 0; i--) if (m_pend[i]) m_off = i;
      m_valid = 1;
    end
    m_pend = press | (m_pend & ~clr);
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [3:0] ef;
    @(negedge clk);
    if (chk_en) begin
      ef = m_valid ? 4'(1 << m_off) : 4'b0;
      checks++;
      if (req_valid !== m_valid || req_floor !== ef || pending !== m_pend) begin
        failures++;
        $display("FAIL model t=%0t got v=%b f=%b p=%b exp v=%b f=%b p=%b",
                 $time, req_valid, req_floor, pending, m_valid, ef, m_pend);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       ack;
    int         n;
    logic       vld;
    logic [3:0] flr;
    logic [3:0] pnd;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] b, logic a, int n,
                              logic v, logic [3:0] f, logic [3:0] p, string nm);
    vec_t t;
    t.rst = r; t.btn = b; t.ack = a; t.n = n;
    t.vld = v; t.flr = f; t.pnd = p; t.name = nm;
    return t;
  endfunction

  initial begin
    // reset state
    tbl.push_back(mk(1, 4'b0000, 0, 2, 0, 4'b0000, 4'b0000, "reset"));
    // single press of floor 3
    tbl.push_back(mk(0, 4'b0100, 0, 5, 0, 4'b0000, 4'b0000, "sp_before"));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 0, 4'b0000, 4'b0100, "sp_pending"));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 1, 4'b0100, 4'b0100, "sp_offer"));
    tbl.push_back(mk(0, 4'b0100, 0, 4, 1, 4'b0100, 4'b0100, "sp_hold1"));
    tbl.push_back(mk(0, 4'b0000, 0, 16, 1, 4'b0100, 4'b0100, "sp_hold2"));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, "sp_ack"));
    tbl.push_back(mk(0, 4'b0000, 0, 5, 0, 4'b0000, 4'b0000, "sp_release"));
    // glitch shorter than the debounce window
    tbl.push_back(mk(0, 4'b0001, 0, 3, 0, 4'b0000, 4'b0000, "gl_high"));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 0, 4'b0000, 4'b0000, "gl_after"));
    // floors 4 and 2 together, ack held
    tbl.push_back(mk(0, 4'b1010, 0, 5, 0, 4'b0000, 4'b0000, "pr_before"));
    tbl.push_back(mk(0, 4'b1010, 0, 1, 0, 4'b0000, 4'b1010, "pr_pending"));
    tbl.push_back(mk(0, 4'b1010, 1, 1, 1, 4'b0010, 4'b1010, "pr_offer2"));
    tbl.push_back(mk(0, 4'b1010, 1, 1, 0, 4'b0000, 4'b1000, "pr_xfer2"));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 1, 4'b1000, 4'b1000, "pr_offer4"));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, "pr_xfer4"));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 0, 4'b0000, 4'b0000, "pr_quiet"));
    // re-press of floor 3 landing on the ack edge
    tbl.push_back(mk(0, 4'b0100, 0, 6, 0, 4'b0000, 4'b0100, "rp_pending"));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0100, 4'b0100, "rp_offer"));
    tbl.push_back(mk(0, 4'b0000, 0, 6, 1, 4'b0100, 4'b0100, "rp_released"));
    tbl.push_back(mk(0, 4'b0100, 0, 5, 1, 4'b0100, 4'b0100, "rp_repress"));
    tbl.push_back(mk(0, 4'b0100, 1, 1, 0, 4'b0000, 4'b0100, "rp_ack_press"));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 1, 4'b0100, 4'b0100, "rp_reoffer"));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, "rp_xfer"));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 0, 4'b0000, 4'b0000, "rp_quiet"));
    // held button gives one transfer only
    tbl.push_back(mk(0, 4'b0010, 0, 6, 0, 4'b0000, 4'b0010, "hd_pending"));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 4'b0010, 4'b0010, "hd_offer"));
    tbl.push_back(mk(0, 4'b0010, 1, 1, 0, 4'b0000, 4'b0000, "hd_xfer"));
    tbl.push_back(mk(0, 4'b0010, 0, 93, 0, 4'b0000, 4'b0000, "hd_norepeat"));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 0, 4'b0000, 4'b0000, "hd_quiet"));
    // reset in the middle of an offer
    tbl.push_back(mk(0, 4'b0011, 0, 6, 0, 4'b0000, 4'b0011, "rs_pending"));
    tbl.push_back(mk(0, 4'b0011, 0, 1, 1, 4'b0001, 4'b0011, "rs_offer"));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, "rs_reset"));
    tbl.push_back(mk(0, 4'b0000, 0, 20, 0, 4'b0000, 4'b0000, "rs_quiet"));

    @(negedge clk);
    foreach (tbl[k]) begin
      reset = tbl[k].rst; btn = tbl[k].btn; req_ack = tbl[k].ack;
      repeat (tbl[k].n) @(negedge clk);
      checks++;
      if (req_valid !== tbl[k].vld || req_floor !== tbl[k].flr || pending !== tbl[k].pnd) begin
        failures++;
        $display("FAIL %s got v=%b f=%b p=%b exp v=%b f=%b p=%b", tbl[k].name,
                 req_valid, req_floor, pending, tbl[k].vld, tbl[k].flr, tbl[k].pnd);
      end
      chk_en = 1'b1;
    end

    // random phase: slowly changing buttons, random ack, rare resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      req_ack = $urandom_range(0, 1) == 1;
      reset   = $urandom_range(0, 499) == 0;
      @(negedge clk);
    end
    reset = 1'b0; btn = 4'b0; req_ack = 1'b1;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
